// File: rtl/fc_layer_pgen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fc_layer_pgen
// Purpose  : Parametrised fully-connected layer, y = act(W*x + b).
//            Weights and biases sit in writable RAM loaded over the cfg port.
//            An input vector of N signed T-bit elements is streamed in, then
//            M/P groups of P rows are computed on P parallel MAC lanes. Each
//            accumulator is scaled by >>> FRAC, saturated to T bits, passed
//            through the run-time selected activation and streamed out.
// Ports    : clk, reset (async, active-high)
//            input_valid/input_ready/input_data    - x[k] stream in
//            output_valid/output_ready/output_data - y[i] stream out
//            cfg_wr_en/cfg_addr/cfg_data           - W[r][c] at r*N+c,
//                                                    b[r] at M*N+r
//            act_mode - 0/3 identity, 1 ReLU, 2 leaky ReLU (x>>>3)
//            busy     - high whenever not waiting for an input vector
// Revision : 1.0 - initial release
// ============================================================================
module fc_layer_pgen #(
  parameter int M    = 8,
  parameter int N    = 8,
  parameter int T    = 16,
  parameter int P    = 2,
  parameter int FRAC = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     input_valid,
  output logic                     input_ready,
  input  logic [T-1:0]             input_data,
  output logic                     output_valid,
  input  logic                     output_ready,
  output logic [T-1:0]             output_data,
  input  logic                     cfg_wr_en,
  input  logic [$clog2(M*N+M)-1:0] cfg_addr,
  input  logic [T-1:0]             cfg_data,
  input  logic [1:0]               act_mode,
  output logic                     busy
);

  localparam int G    = M / P;
  localparam int ACCW = 2*T + $clog2(N) + 1;
  localparam int IW   = (N > 1) ? $clog2(N) : 1;
  localparam int GW   = (G > 1) ? $clog2(G) : 1;
  localparam int LW   = (P > 1) ? $clog2(P) : 1;
  localparam int WAW  = (M*N > 1) ? $clog2(M*N) : 1;
  localparam int BAW  = (M > 1) ? $clog2(M) : 1;

  localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-T+1){1'b0}}, {(T-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-T+1){1'b1}}, {(T-1){1'b0}}};

  typedef enum logic [2:0] {
    S_LOAD  = 3'd0,
    S_MAC   = 3'd1,
    S_FLUSH = 3'd2,
    S_ACT   = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          k_q, k_d;
  logic [IW-1:0]          j_q, j_d;
  logic [GW-1:0]          g_q, g_d;
  logic [LW-1:0]          lane_q, lane_d;
  logic [1:0]             mode_q, mode_d;
  logic signed [T-1:0]    x_rd_q, x_rd_d;
  logic signed [T-1:0]    w_rd_q [P];
  logic signed [T-1:0]    w_rd_d [P];
  logic signed [ACCW-1:0] acc_q [P];
  logic signed [ACCW-1:0] acc_d [P];
  logic signed [T-1:0]    out_buf_q [P];
  logic signed [T-1:0]    out_buf_d [P];
  logic                   output_valid_q, output_valid_d;
  logic signed [T-1:0]    output_data_q, output_data_d;

  logic signed [2*T-1:0]  prod [P];
  logic signed [T-1:0]    res [P];
  logic                   in_xfer;
  logic                   cfg_ok;
  logic                   w_wr;
  logic                   b_wr;

  // Storage without reset: contents survive a mid-operation reset.
  logic signed [T-1:0]    w_mem [M*N];
  logic signed [T-1:0]    b_mem [M];
  logic signed [T-1:0]    x_mem [N];

  // Scale, saturate, then activate.
  function automatic logic signed [T-1:0] post_proc(input logic signed [ACCW-1:0] acc,
                                                    input logic [1:0] mode);
    logic signed [ACCW-1:0] sh;
    logic signed [T-1:0]    sat;
    sh = acc >>> FRAC;
    if (sh > SAT_MAX)      sat = SAT_MAX[T-1:0];
    else if (sh < SAT_MIN) sat = SAT_MIN[T-1:0];
    else                   sat = sh[T-1:0];
    case (mode)
      2'd1:    return sat[T-1] ? '0 : sat;
      2'd2:    return sat[T-1] ? (sat >>> 3) : sat;
      default: return sat;
    endcase
  endfunction

  assign input_ready  = (state_q == S_LOAD) && !reset;
  assign busy         = (state_q != S_LOAD);
  assign output_valid = output_valid_q;
  assign output_data  = output_data_q;
  assign in_xfer      = input_valid && input_ready;

  // Config is only accepted while idle between vectors.
  assign cfg_ok = cfg_wr_en && (state_q == S_LOAD) && (k_q == '0);
  assign w_wr   = cfg_ok && (32'(cfg_addr) < M*N);
  assign b_wr   = cfg_ok && (32'(cfg_addr) >= M*N) && (32'(cfg_addr) < M*N + M);

  always_ff @(posedge clk) begin
    if (in_xfer) x_mem[k_q] <= input_data;
    if (w_wr)    w_mem[cfg_addr[WAW-1:0]] <= cfg_data;
    if (b_wr)    b_mem[BAW'(32'(cfg_addr) - M*N)] <= cfg_data;
  end

  always_comb begin
    for (int l = 0; l < P; l++) begin
      prod[l] = x_rd_q * w_rd_q[l];
      res[l]  = post_proc(acc_q[l], mode_q);
    end
  end

  always_comb begin
    state_d        = state_q;
    k_d            = k_q;
    j_d            = j_q;
    g_d            = g_q;
    lane_d         = lane_q;
    mode_d         = mode_q;
    x_rd_d         = x_rd_q;
    w_rd_d         = w_rd_q;
    acc_d          = acc_q;
    out_buf_d      = out_buf_q;
    output_valid_d = output_valid_q;
    output_data_d  = output_data_q;

    case (state_q)
      S_LOAD: begin
        if (in_xfer) begin
          if (k_q == '0) mode_d = act_mode;
          if (k_q == IW'(N-1)) begin
            k_d     = '0;
            j_d     = '0;
            g_d     = '0;
            state_d = S_MAC;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end

      // Reads for column j issue here; the product lands one cycle later,
      // so column 0's read cycle seeds the accumulator with the bias.
      S_MAC: begin
        x_rd_d = x_mem[j_q];
        for (int l = 0; l < P; l++) begin
          w_rd_d[l] = w_mem[WAW'((int'(g_q)*P + l)*N + int'(j_q))];
          if (j_q == '0)
            acc_d[l] = ACCW'(b_mem[BAW'(int'(g_q)*P + l)]) <<< FRAC;
          else
            acc_d[l] = acc_q[l] + ACCW'(prod[l]);
        end
        if (j_q == IW'(N-1)) state_d = S_FLUSH;
        else                 j_d     = j_q + 1'b1;
      end

      S_FLUSH: begin
        for (int l = 0; l < P; l++) acc_d[l] = acc_q[l] + ACCW'(prod[l]);
        state_d = S_ACT;
      end

      S_ACT: begin
        out_buf_d      = res;
        output_data_d  = res[0];
        output_valid_d = 1'b1;
        lane_d         = '0;
        state_d        = S_OUT;
      end

      S_OUT: begin
        if (output_ready) begin
          if (lane_q == LW'(P-1)) begin
            output_valid_d = 1'b0;
            lane_d         = '0;
            if (g_q == GW'(G-1)) begin
              k_d     = '0;
              state_d = S_LOAD;
            end else begin
              g_d     = g_q + 1'b1;
              j_d     = '0;
              state_d = S_MAC;
            end
          end else begin
            lane_d        = lane_q + 1'b1;
            output_data_d = out_buf_q[lane_q + 1'b1];
          end
        end
      end

      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_LOAD;
      k_q            <= '0;
      j_q            <= '0;
      g_q            <= '0;
      lane_q         <= '0;
      mode_q         <= '0;
      x_rd_q         <= '0;
      output_valid_q <= 1'b0;
      output_data_q  <= '0;
      for (int l = 0; l < P; l++) begin
        w_rd_q[l]    <= '0;
        acc_q[l]     <= '0;
        out_buf_q[l] <= '0;
      end
    end else begin
      state_q        <= state_d;
      k_q            <= k_d;
      j_q            <= j_d;
      g_q            <= g_d;
      lane_q         <= lane_d;
      mode_q         <= mode_d;
      x_rd_q         <= x_rd_d;
      output_valid_q <= output_valid_d;
      output_data_q  <= output_data_d;
      w_rd_q         <= w_rd_d;
      acc_q          <= acc_d;
      out_buf_q      <= out_buf_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fc_layer_pgen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fc_layer_pgen
// Purpose  : Directed self-checking bench for fc_layer_pgen. Instance A is a
//            small 8-bit 2x2 single-lane layer; instance B is a 16-bit 4x2
//            two-lane layer with FRAC=4. Both share clock, reset and the
//            cfg/data/act buses; each has its own valid strobes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fc_layer_pgen;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_in_valid, b_in_valid;
  logic        a_in_ready, b_in_ready;
  logic [15:0] in_data;
  logic        a_out_valid, b_out_valid;
  logic        out_ready;
  logic [7:0]  a_out_data;
  logic [15:0] b_out_data;
  logic        a_cfg_wr, b_cfg_wr;
  logic [3:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic [1:0]  act_mode;
  logic        a_busy, b_busy;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int last_x_cyc;
  int got_y [8];
  int got_c [8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fc_layer_pgen #(.M(2), .N(2), .T(8), .P(1), .FRAC(0)) dut_a (
    .clk(clk), .reset(rst),
    .input_valid(a_in_valid), .input_ready(a_in_ready), .input_data(in_data[7:0]),
    .output_valid(a_out_valid), .output_ready(out_ready), .output_data(a_out_data),
    .cfg_wr_en(a_cfg_wr), .cfg_addr(cfg_addr[2:0]), .cfg_data(cfg_data[7:0]),
    .act_mode(act_mode), .busy(a_busy)
  );

  fc_layer_pgen #(.M(4), .N(2), .T(16), .P(2), .FRAC(4)) dut_b (
    .clk(clk), .reset(rst),
    .input_valid(b_in_valid), .input_ready(b_in_ready), .input_data(in_data),
    .output_valid(b_out_valid), .output_ready(out_ready), .output_data(b_out_data),
    .cfg_wr_en(b_cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .act_mode(act_mode), .busy(b_busy)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  function automatic int get_valid(input int sel);
    return (sel == 0) ? int'(a_out_valid) : int'(b_out_valid);
  endfunction

  function automatic int get_ready(input int sel);
    return (sel == 0) ? int'(a_in_ready) : int'(b_in_ready);
  endfunction

  function automatic int get_data(input int sel);
    return (sel == 0) ? int'($signed(a_out_data)) : int'($signed(b_out_data));
  endfunction

  // All tasks start and end 1 ns after a rising edge.
  task automatic cfg(input int sel, input int addr, input int data);
    cfg_addr = addr[3:0];
    cfg_data = data[15:0];
    if (sel == 0) a_cfg_wr = 1'b1; else b_cfg_wr = 1'b1;
    @(posedge clk); #1;
    a_cfg_wr = 1'b0;
    b_cfg_wr = 1'b0;
  endtask

  task automatic send_vec(input int sel, input int mode, input int x0, input int x1);
    int xs [2];
    int guard;
    xs[0] = x0;
    xs[1] = x1;
    act_mode = mode[1:0];
    for (int k = 0; k < 2; k++) begin
      in_data = xs[k][15:0];
      if (sel == 0) a_in_valid = 1'b1; else b_in_valid = 1'b1;
      guard = 0;
      while (get_ready(sel) == 0 && guard < 50) begin
        @(posedge clk); #1;
        guard++;
      end
      check_eq("in_ready_wait", get_ready(sel), 1);
      if (k == 1) last_x_cyc = cyc;
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
  endtask

  // Collect n outputs; output number stall_idx is held off for 10 cycles.
  task automatic collect(input int sel, input int n, input int stall_idx);
    int cnt;
    int guard;
    int hold;
    cnt   = 0;
    guard = 0;
    while (cnt < n && guard < 200) begin
      if (get_valid(sel) != 0) begin
        if (cnt == stall_idx) begin
          hold      = get_data(sel);
          out_ready = 1'b0;
          repeat (10) begin
            @(posedge clk); #1;
            check_eq("stall_valid", get_valid(sel), 1);
            check_eq("stall_data", get_data(sel), hold);
            check_eq("stall_in_ready", get_ready(sel), 0);
          end
          out_ready = 1'b1;
        end
        got_y[cnt] = get_data(sel);
        got_c[cnt] = cyc;
        cnt++;
      end
      if (cnt < n) begin
        @(posedge clk); #1;
        guard++;
      end
    end
    check_eq("out_count", cnt, n);
    @(posedge clk); #1;
    check_eq("out_tail_valid", get_valid(sel), 0);
  endtask

  task automatic run_vec(input int sel, input int n, input int mode,
                         input int x0, input int x1, input int stall_idx);
    send_vec(sel, mode, x0, x1);
    collect(sel, n, stall_idx);
  endtask

  initial begin
    rst        = 1'b0;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    in_data    = '0;
    out_ready  = 1'b1;
    a_cfg_wr   = 1'b0;
    b_cfg_wr   = 1'b0;
    cfg_addr   = '0;
    cfg_data   = '0;
    act_mode   = '0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready", a_in_ready, 0);
    check_eq("rst_out_valid", a_out_valid, 0);
    check_eq("rst_out_data", a_out_data, 0);
    check_eq("rst_busy", a_busy, 0);
    check_eq("rst_b_out_valid", b_out_valid, 0);
    rst = 1'b0;
    #1;
    check_eq("rel_in_ready_a", a_in_ready, 1);
    check_eq("rel_in_ready_b", b_in_ready, 1);
    @(posedge clk); #1;

    // A: W = [[1,2],[-3,1]], b = [0,0]
    cfg(0, 0, 1); cfg(0, 1, 2); cfg(0, 2, -3); cfg(0, 3, 1); cfg(0, 4, 0); cfg(0, 5, 0);

    run_vec(0, 2, 0, 5, 4, -1);
    check_eq("lat_a", got_c[0] - last_x_cyc, 5);
    check_eq("id_y0", got_y[0], 13);
    check_eq("id_y1", got_y[1], -11);
    run_vec(0, 2, 1, 5, 4, -1);
    check_eq("relu_y0", got_y[0], 13);
    check_eq("relu_y1", got_y[1], 0);
    run_vec(0, 2, 2, 5, 4, -1);
    check_eq("leaky_y0", got_y[0], 13);
    check_eq("leaky_y1", got_y[1], -2);
    run_vec(0, 2, 3, 5, 4, -1);
    check_eq("mode3_y1", got_y[1], -11);

    // Config write during MAC must be dropped.
    send_vec(0, 0, 5, 4);
    check_eq("busy_mac", a_busy, 1);
    cfg(0, 0, 50);
    collect(0, 2, -1);
    check_eq("busy_cfg_y0", got_y[0], 13);
    check_eq("busy_cfg_y1", got_y[1], -11);
    run_vec(0, 2, 0, 5, 4, -1);
    check_eq("rerun_y0", got_y[0], 13);
    cfg(0, 0, 2);
    run_vec(0, 2, 0, 5, 4, -1);
    check_eq("load_cfg_y0", got_y[0], 18);
    check_eq("load_cfg_y1", got_y[1], -11);
    cfg(0, 0, 1);

    // Reset during MAC, weights retained.
    send_vec(0, 0, 5, 4);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_eq("midrst_out_valid", a_out_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_eq("postrst_in_ready", a_in_ready, 1);
    check_eq("postrst_out_valid", a_out_valid, 0);
    check_eq("postrst_busy", a_busy, 0);
    run_vec(0, 2, 0, 5, 4, -1);
    check_eq("postrst_y0", got_y[0], 13);
    check_eq("postrst_y1", got_y[1], -11);

    // Saturation.
    cfg(0, 0, 100); cfg(0, 1, 100);
    run_vec(0, 2, 0, 100, 100, -1);
    check_eq("sat_hi_y0", got_y[0], 127);
    check_eq("sat_lo_y1", got_y[1], -128);
    cfg(0, 0, -100);
    run_vec(0, 2, 0, 100, -100, -1);
    check_eq("sat_lo_y0", got_y[0], -128);

    // B: FRAC=4, two lanes, bias, backpressure on lane 1 of group 0.
    cfg(1, 0, 16); cfg(1, 1, 0);  cfg(1, 2, 0);  cfg(1, 3, 16);
    cfg(1, 4, 8);  cfg(1, 5, 8);  cfg(1, 6, 16); cfg(1, 7, 16);
    cfg(1, 8, 1);  cfg(1, 9, 0);  cfg(1, 10, 0); cfg(1, 11, -2);
    run_vec(1, 4, 0, 32, 48, 1);
    check_eq("lat_b", got_c[0] - last_x_cyc, 5);
    check_eq("grp_gap_b", got_c[2] - got_c[1], 5);
    check_eq("frac_y0", got_y[0], 33);
    check_eq("frac_y1", got_y[1], 48);
    check_eq("frac_y2", got_y[2], 40);
    check_eq("frac_y3", got_y[3], 78);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
